// File: rtl/uart_status_pkg.sv
// Shared types, ASCII constants and the message byte table for the
// UART status reporter.
package uart_status_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} core_state_t;
  typedef enum logic {SEQ_IDLE, SEQ_SEND} seq_state_t;

  localparam logic [7:0] ASCII_X  = 8'h58;
  localparam logic [7:0] ASCII_Y  = 8'h59;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_Q  = 8'h3F;

  localparam int MSG_LEN = 9;

  // Out-of-range coordinates show up as '?' so the host notices them.
  function automatic logic [7:0] ascii_digit(input logic [7:0] v);
    return (v <= 8'd9) ? (ASCII_0 + v) : ASCII_Q;
  endfunction

  // Line layout: "X=<dx> Y=<dy>\r\n"
  function automatic logic [7:0] msg_byte(input logic [3:0] idx,
                                          input logic [7:0] sx,
                                          input logic [7:0] sy);
    case (idx)
      4'd0:    return ASCII_X;
      4'd1:    return ASCII_EQ;
      4'd2:    return ascii_digit(sx);
      4'd3:    return ASCII_SP;
      4'd4:    return ASCII_Y;
      4'd5:    return ASCII_EQ;
      4'd6:    return ascii_digit(sy);
      4'd7:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

endpackage

// File: rtl/uart_status_tx_if.sv
// Coordinate inputs, request strobe and serial/status outputs of the
// status reporter, bundled for connection to the keyboard side.
interface uart_status_tx_if;
  logic [7:0] x;
  logic [7:0] y;
  logic       send_req;
  logic       tx;
  logic       busy;
  logic       msg_done;

  modport master (output x, y, send_req, input tx, busy, msg_done);
  modport slave  (input x, y, send_req, output tx, busy, msg_done);
endinterface

// File: rtl/uart_tx_core.sv
// 8N1 byte serialiser. A load while the final stop cycle is flagged by done
// chains straight into the next start bit with no idle gap.
module uart_tx_core
  import uart_status_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  output logic       tx,
  output logic       done,
  output logic       ready
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DONE_CNT = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] ONE      = CW'(1);

  core_state_t   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          tick;

  assign tick  = (baud_cnt == LAST_CNT);
  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      done      <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (load) begin
            shift_reg <= din;
            baud_cnt  <= '0;
            tx        <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (tick) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + ONE;
          end
        end
        DATA: begin
          if (tick) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + ONE;
          end
        end
        STOP: begin
          if (tick) begin
            baud_cnt <= '0;
            if (load) begin
              shift_reg <= din;
              tx        <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + ONE;
            // Raised one cycle early so done covers exactly the last stop cycle.
            done     <= (baud_cnt == DONE_CNT);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_status_tx.sv
// Status line sequencer: snapshots x/y, walks the 9-byte message through
// the serialiser and queues one follow-up when a trigger arrives mid-message.
module uart_status_tx
  import uart_status_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int MSG_LEN      = uart_status_pkg::MSG_LEN
) (
  input  logic             clk,
  input  logic             reset,
  uart_status_tx_if.slave  bus
);

  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  seq_state_t seq_state;
  logic [7:0] sx;
  logic [7:0] sy;
  logic       pending;
  logic [3:0] byte_idx;
  logic       busy_reg;

  logic       trig;
  logic       last_byte;
  logic       load;
  logic [7:0] din;
  logic       core_tx;
  logic       core_done;
  logic       core_ready;

  // Snapshot resets to FFFF, which no real target matches, forcing a first message.
  assign trig      = bus.send_req | ({bus.x, bus.y} != {sx, sy});
  assign last_byte = (byte_idx == LAST_IDX);

  always_comb begin
    load = 1'b0;
    din  = msg_byte(4'd0, sx, sy);
    case (seq_state)
      SEQ_IDLE: load = (trig | pending) & core_ready;
      SEQ_SEND: begin
        if (core_done && !last_byte) begin
          load = 1'b1;
          din  = msg_byte(byte_idx + 4'd1, sx, sy);
        end
      end
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_state <= SEQ_IDLE;
      sx        <= 8'hFF;
      sy        <= 8'hFF;
      pending   <= 1'b0;
      byte_idx  <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (seq_state)
        SEQ_IDLE: begin
          if ((trig || pending) && core_ready) begin
            sx        <= bus.x;
            sy        <= bus.y;
            pending   <= 1'b0;
            byte_idx  <= '0;
            busy_reg  <= 1'b1;
            seq_state <= SEQ_SEND;
          end
        end
        SEQ_SEND: begin
          if (trig)
            pending <= 1'b1;
          if (core_done) begin
            if (last_byte) begin
              busy_reg  <= 1'b0;
              seq_state <= SEQ_IDLE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end
        default: seq_state <= SEQ_IDLE;
      endcase
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .din   (din),
    .tx    (core_tx),
    .done  (core_done),
    .ready (core_ready)
  );

  assign bus.tx       = core_tx;
  assign bus.busy     = busy_reg;
  assign bus.msg_done = (seq_state == SEQ_SEND) & core_done & last_byte;

endmodule

// File: tb/tb_uart_status_tx.sv
// Bench for uart_status_tx: two instances (4 and 2 clocks per bit) share
// one stimulus stream; each is checked every cycle against a timeline model.
module tb_uart_status_tx;

  typedef struct packed {
    logic [31:0] n;
    logic [31:0] start;
    logic        busy;
    logic        pend;
    logic [7:0]  sx;
    logic [7:0]  sy;
  } mstate_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] x_in = 8'd3;
  logic [7:0] y_in = 8'd4;
  logic       send_req = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [7:0] digit(input logic [7:0] v);
    return (v < 8'd10) ? (8'h30 + v) : 8'h3F;
  endfunction

  function automatic logic [7:0] spec_byte(input int i, input logic [7:0] sx, input logic [7:0] sy);
    case (i)
      0:       return 8'h58;
      1:       return 8'h3D;
      2:       return digit(sx);
      3:       return 8'h20;
      4:       return 8'h59;
      5:       return 8'h3D;
      6:       return digit(sy);
      7:       return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // Advance the model over one clock edge using the inputs present before it.
  function automatic mstate_t model_step(input mstate_t s, input int p, input logic rst,
                                         input logic sreq, input logic [7:0] xv, input logic [7:0] yv);
    mstate_t r;
    bit tr;
    r = s;
    r.n = s.n + 32'd1;
    tr = sreq || (xv != s.sx) || (yv != s.sy);
    if (rst) begin
      r.busy = 1'b0;
      r.pend = 1'b0;
      r.sx = 8'hFF;
      r.sy = 8'hFF;
    end else if (s.busy) begin
      if (tr) r.pend = 1'b1;
      if (int'(r.n) - 1 - int'(s.start) == 90 * p - 1) r.busy = 1'b0;
    end else if (tr || s.pend) begin
      r.busy = 1'b1;
      r.pend = 1'b0;
      r.sx = xv;
      r.sy = yv;
      r.start = r.n;
    end
    return r;
  endfunction

  // Expected {tx, busy, msg_done} for the current cycle from the message timeline.
  function automatic logic [2:0] model_out(input mstate_t s, input int p);
    int off;
    int b;
    logic [7:0] byt;
    logic t;
    if (!s.busy) return 3'b100;
    off = int'(s.n) - int'(s.start);
    byt = spec_byte(off / (10 * p), s.sx, s.sy);
    b = (off % (10 * p)) / p;
    t = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : byt[b - 1];
    return {t, 1'b1, (off == 90 * p - 1)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_dut
    localparam int P = (gi == 0) ? 4 : 2;
    uart_status_tx_if bus ();
    mstate_t m;

    assign bus.x = x_in;
    assign bus.y = y_in;
    assign bus.send_req = send_req;

    uart_status_tx #(
      .CLKS_PER_BIT(P),
      .MSG_LEN(9)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    initial begin
      m = '0;
      forever begin
        @(posedge clk);
        m = model_step(m, P, reset, send_req, x_in, y_in);
      end
    end
  end

  logic tx0, busy0, done0, tx1, busy1, done1;
  assign tx0   = g_dut[0].bus.tx;
  assign busy0 = g_dut[0].bus.busy;
  assign done0 = g_dut[0].bus.msg_done;
  assign tx1   = g_dut[1].bus.tx;
  assign busy1 = g_dut[1].bus.busy;
  assign done1 = g_dut[1].bus.msg_done;

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (checking) begin
      chk("cpb4 {tx,busy,msg_done}", {29'd0, tx0, busy0, done0}, {29'd0, model_out(g_dut[0].m, 4)});
      chk("cpb2 {tx,busy,msg_done}", {29'd0, tx1, busy1, done1}, {29'd0, model_out(g_dut[1].m, 2)});
    end
  end

  // Mid-bit UART receiver for the 4-clock instance plus msg_done bookkeeping.
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte = 8'h00;
  bit rx_act = 1'b0;
  int rx_cnt = 0;
  int msg_start_cyc = -1;
  int done_cnt = 0;
  int last_done_cyc = -1;
  int d2_low = -1;
  int d2_done = -1;

  initial forever begin
    @(negedge clk);
    if (done0 === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (checking && d2_low < 0 && tx1 === 1'b0) d2_low = cyc;
    if (checking && d2_done < 0 && done1 === 1'b1) d2_done = cyc;
    if (reset) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx0 === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
        if (rx_q.size() == 0) msg_start_cyc = cyc;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_byte[(rx_cnt - 6) / 4] = tx0;
      if (rx_cnt == 39) begin
        rx_act = 1'b0;
        rx_q.push_back(rx_byte);
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input string nm);
    int k;
    k = 0;
    while (done_cnt < target && k < 800) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({nm, " msg_done reached"}, {31'd0, done_cnt >= target}, 32'd1);
  endtask

  task automatic chk_msg(input logic [71:0] e, input string nm);
    logic [31:0] a;
    chk({nm, " byte count"}, rx_q.size(), 32'd9);
    for (int i = 0; i < 9; i++) begin
      a = (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD_BEEF;
      chk($sformatf("%s byte%0d", nm, i), a, {24'd0, e[71 - 8 * i -: 8]});
    end
    rx_q.delete();
  endtask

  initial begin
    int d3;
    tick(1);
    checking = 1'b1;
    tick(2);
    chk("reset tx", {31'd0, tx0}, 32'd1);
    chk("reset busy", {31'd0, busy0}, 32'd0);
    chk("reset msg_done", {31'd0, done0}, 32'd0);

    // 1: message after reset
    reset = 1'b0;
    tick(1);
    chk("t1 start bit after reset", {31'd0, tx0}, 32'd0);
    wait_done(1, "t1");
    chk("t1 message length cycles", last_done_cyc - msg_start_cyc, 32'd359);
    chk_msg(72'h58_3D_33_20_59_3D_34_0D_0A, "t1");
    chk("t1 tx idle after", {31'd0, tx0}, 32'd1);

    // 2: steady inputs stay quiet, then a forced repeat
    tick(1000);
    chk("t2 no extra msg_done", done_cnt, 32'd1);
    chk("t2 no extra bytes", rx_q.size(), 32'd0);
    send_req = 1'b1;
    tick(1);
    send_req = 1'b0;
    chk("t2 start bit after send_req", {31'd0, tx0}, 32'd0);
    wait_done(2, "t2");
    chk_msg(72'h58_3D_33_20_59_3D_34_0D_0A, "t2");

    // 3: two changes mid-message coalesce into one follow-up
    send_req = 1'b1;
    tick(1);
    send_req = 1'b0;
    tick(90);
    x_in = 8'd2;
    tick(10);
    x_in = 8'd1;
    wait_done(3, "t3a");
    d3 = last_done_cyc;
    chk_msg(72'h58_3D_33_20_59_3D_34_0D_0A, "t3a");
    wait_done(4, "t3b");
    chk("t3 follow-up gap", msg_start_cyc - d3, 32'd2);
    chk_msg(72'h58_3D_31_20_59_3D_34_0D_0A, "t3b");
    tick(50);
    chk("t3 single follow-up", done_cnt, 32'd4);

    // 4: out-of-range and zero digits
    x_in = 8'd12;
    y_in = 8'd0;
    wait_done(5, "t4");
    chk_msg(72'h58_3D_3F_20_59_3D_30_0D_0A, "t4");

    // 5: reset in the middle of byte 5's data bits
    x_in = 8'd5;
    y_in = 8'd6;
    tick(1);
    chk("t5 start bit", {31'd0, tx0}, 32'd0);
    tick(210);
    reset = 1'b1;
    tick(1);
    chk("t5 tx high after reset", {31'd0, tx0}, 32'd1);
    chk("t5 busy low after reset", {31'd0, busy0}, 32'd0);
    reset = 1'b0;
    rx_q.delete();
    tick(1);
    chk("t5 restart after reset", {31'd0, tx0}, 32'd0);
    wait_done(6, "t5");
    chk_msg(72'h58_3D_35_20_59_3D_36_0D_0A, "t5");

    // 6: two-clock bit instance ran the same stimulus; pin its first message length
    tick(20);
    chk("t6 cpb2 first message cycles", d2_done - d2_low, 32'd179);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_status_tx.md
Name: uart_status_tx

Overview:
- UART transmitter: the return path of the keyboard link. Reports the current servo target (x,y) back to the host terminal as an ASCII line.
- Sits beside the keyboard controller and takes its x/y outputs directly.
- Sends a 9-byte message "X=<d> Y=<d>\r\n" whenever x or y changes, or on explicit request.
- Serialises 8N1, LSB first, on the tx pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2
MSG_LEN, 9, bytes per status message (fixed; exposed for the bench only)

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
x  in  8  current x target (expected 1..9)
y  in  8  current y target (expected 1..9)
send_req  in  1  single-cycle pulse that forces a message even if x,y are unchanged
tx  out  1  UART serial out, idle high
busy  out  1  high while a message is in flight
msg_done  out  1  one-cycle pulse on the last cycle of the final stop bit of a message

Behaviour:
- Reset values: tx=1, busy=0, msg_done=0, core FSM=IDLE, sequencer=SEQ_IDLE, snapshot {sx,sy}=16'hFFFF, pending=0. The snapshot value guarantees that one message is sent after reset.
- Trigger: trig = send_req | ({x,y} != {sx,sy}).
  - Evaluated every cycle in SEQ_IDLE.
  - While busy, a trig event sets pending; it is not dropped.
- Message start:
  - The sequencer in SEQ_IDLE with trig or pending latches {sx,sy} <= {x,y}, clears pending, sets busy=1 and presents byte 0 to the core, all on the same edge.
  - Latency: trigger seen at edge k -> tx low (start bit) from edge k+1.
- Byte table, index 0..8:
  - 'X'(0x58), '='(0x3D), dx, ' '(0x20), 'Y'(0x59), '='(0x3D), dy, CR(0x0D), LF(0x0A).
  - dv = 0x30+v for v in 0..9; any v > 9 gives '?'(0x3F).
  - dx/dy come from the latched snapshot, never the live inputs. Input changes mid-message therefore do not corrupt the line.
- Core FSM (sub-module), states IDLE, START, DATA, STOP:
  - IDLE: tx=1. On load, latch the byte and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each. The 3-bit bit counter advances on the baud tick.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then done pulses 1 cycle and the core returns to IDLE.
  - A load coincident with done goes straight to START with no idle gap. Back-to-back bytes inside a message therefore have zero inter-frame gap.
- Baud counter: counts 0..CLKS_PER_BIT-1, reloads at each bit boundary, and is cleared on load. Frame length is exactly 10*CLKS_PER_BIT cycles.
- Sequencer, states SEQ_IDLE, SEQ_SEND:
  - In SEQ_SEND, on core done: if index < 8, index++ and load the next byte.
  - If index == 8: msg_done=1, busy=0, go to SEQ_IDLE.
- After msg_done, SEQ_IDLE re-evaluates trig/pending on the next cycle.
  - If x,y moved during the message, a new message starts one cycle after msg_done (idle high for 1 cycle).
  - Multiple changes during one message coalesce into a single follow-up message carrying the latest values.
- send_req while busy sets pending and produces exactly one extra message.
- Reset mid-frame: tx returns to 1 on the next edge. The partial frame is abandoned, not completed. Snapshot goes back to FFFF, so a fresh message follows reset deassertion.

Decomposition:
- Package uart_status_pkg holds:
  - core state enum {IDLE, START, DATA, STOP} and sequencer enum {SEQ_IDLE, SEQ_SEND};
  - constants ASCII_X, ASCII_Y, ASCII_EQ, ASCII_SP, ASCII_CR, ASCII_LF, ASCII_0, ASCII_Q;
  - MSG_LEN=9.
- One sub-module, uart_tx_core (CLKS_PER_BIT):
  - ports clk, reset, load, din[7:0], tx, done, ready;
  - holds the baud counter and the bit FSM.
- The top level holds the snapshot, pending flag, byte index, and byte-select mux.

Test Plan:
1. Reset with x=3, y=4, CLKS_PER_BIT=4 -> one message; decoded bytes 58 3D 33 20 59 3D 34 0D 0A; each frame 40 cycles, 360 total; msg_done once; tx=1 afterwards.
2. Steady x=3, y=4 for 1000 cycles after message 1 -> tx stays 1, busy stays 0; then send_req pulse -> tx low on the next cycle and the identical message repeats.
3. During byte 2, change x 3->2 then 2->1 -> the current message still carries '3'. Exactly one follow-up message carrying '1' starts 1 cycle after msg_done.
4. x=12, y=0 -> digits 3F and 30.
5. Assert reset for 1 cycle mid-DATA of byte 5 -> tx=1 on the next edge; the next message starts 1 cycle after reset deassertion with the full 9 bytes.
6. CLKS_PER_BIT=2 edge case -> every bit lasts exactly 2 cycles; stop bit is high; no glitch between bytes.
